// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and framing constants.
// Imported by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int CLK_PER_BIT_DEFAULT = 271;

endpackage

// File: rtl/uart_tx_buf_if.sv
// Byte push handshake from the core into the UART transmit buffer.
// The producer holds in_valid/in_data until in_ready is seen high.
interface uart_tx_buf_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/uart_tx_buf_fifo.sv
// Single-clock FIFO with first-word-fall-through head output.
// Writes while full and reads while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !rd_ok) count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
    end
  end

  pop_not_empty: assert property (
    @(posedge clk) disable iff (rst) rd_en |-> !empty
  );

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter, LSB first, frames sent back-to-back.
// Line output is registered; reset forces the line high at once.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  uart_tx_buf_if.slave                in_if,
  output logic                        UART_TX,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  uart_state_t          state, state_d;
  logic [BW-1:0]        baud, baud_d;
  logic [IW-1:0]        idx, idx_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 tx_d;
  logic                 bit_end;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;

  assign in_if.in_ready = !fifo_full;
  assign push    = in_if.in_valid && !fifo_full;
  assign bit_end = baud == BAUD_LAST;
  assign busy    = (state != IDLE) || (fifo_count != '0);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (push),
    .wr_data (in_if.in_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d = state;
    baud_d  = bit_end ? '0 : baud + 1'b1;
    idx_d   = idx;
    shift_d = shift;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift >> 1;
          idx_d   = idx + 1'b1;
          if (idx == IDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        // Chain straight into the next start bit to keep frames gapless
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            idx_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      baud    <= '0;
      idx     <= '0;
      shift   <= '0;
      UART_TX <= 1'b1;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      idx     <= idx_d;
      shift   <= shift_d;
      UART_TX <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: frame-timeline model, line
// decoder and directed plus random push traffic on two configurations.
module tb_uart_tx_buf;
  import uart_pkg::*;

  localparam int CPB0 = 4;
  localparam int DEP0 = 4;
  localparam int CPB1 = 271;
  localparam int DEP1 = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_buf_if bus0 ();
  uart_tx_buf_if bus1 ();

  logic       tx0, tx1, busy0, busy1;
  logic [2:0] cnt0;
  logic [4:0] cnt1;

  uart_tx_buf #(.CLK_PER_BIT(CPB0), .FIFO_DEPTH(DEP0)) dut0 (
    .CLK(clk), .RST(rst), .in_if(bus0),
    .UART_TX(tx0), .busy(busy0), .fifo_count(cnt0)
  );

  uart_tx_buf #(.CLK_PER_BIT(CPB1), .FIFO_DEPTH(DEP1)) dut1 (
    .CLK(clk), .RST(rst), .in_if(bus1),
    .UART_TX(tx1), .busy(busy1), .fifo_count(cnt1)
  );

  logic       v [2];
  logic [7:0] d [2];
  logic       tx [2];
  logic       bsy [2];
  logic       rdy [2];
  int         cnt [2];

  assign bus0.in_valid = v[0];
  assign bus0.in_data  = d[0];
  assign bus1.in_valid = v[1];
  assign bus1.in_data  = d[1];
  assign tx[0]  = tx0;
  assign tx[1]  = tx1;
  assign bsy[0] = busy0;
  assign bsy[1] = busy1;
  assign rdy[0] = bus0.in_ready;
  assign rdy[1] = bus1.in_ready;
  assign cnt[0] = 32'(cnt0);
  assign cnt[1] = 32'(cnt1);

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // model: buffered bytes plus the frame currently on the line
  logic [7:0] mbuf [2][32];
  int         mhead [2];
  int         msize [2];
  logic       m_act [2];
  int         m_pos [2];
  logic [7:0] m_cur [2];
  logic       m_tx [2];
  logic [7:0] acc [2][64];
  int         accn [2];

  // line decoder
  logic       dec_on [2];
  int         dec_t0 [2];
  int         dec_k [2];
  logic [7:0] dec_b [2];
  logic [7:0] rx [2][64];
  int         rxn [2];
  logic       prev_tx [2];
  logic       prev_b0;

  int t_acc, t_fall, t_bfall, peak0;
  int t1_fall, t1_rise;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int cpb_of(int i);
    return (i == 0) ? CPB0 : CPB1;
  endfunction

  function automatic int dep_of(int i);
    return (i == 0) ? DEP0 : DEP1;
  endfunction

  task automatic model_step(int i);
    int  cpb, b;
    bit  end_now, push;
    cpb = cpb_of(i);
    if (rst) begin
      m_act[i] = 1'b0;
      m_pos[i] = 0;
      mhead[i] = 0;
      msize[i] = 0;
      m_tx[i]  = 1'b1;
      return;
    end
    if (m_act[i]) begin
      b = m_pos[i] / cpb;
      if (b == 0) m_tx[i] = 1'b0;
      else if (b == 9) m_tx[i] = 1'b1;
      else m_tx[i] = m_cur[i][b-1];
    end else begin
      m_tx[i] = 1'b1;
    end
    end_now = m_act[i] && (m_pos[i] == 10 * cpb - 1);
    push = v[i] && (msize[i] < dep_of(i));
    if ((!m_act[i] || end_now) && msize[i] > 0) begin
      m_cur[i] = mbuf[i][mhead[i]];
      mhead[i] = (mhead[i] + 1) % 32;
      msize[i]--;
      m_act[i] = 1'b1;
      m_pos[i] = 0;
    end else if (end_now) begin
      m_act[i] = 1'b0;
    end else if (m_act[i]) begin
      m_pos[i]++;
    end
    if (push) begin
      mbuf[i][(mhead[i] + msize[i]) % 32] = d[i];
      msize[i]++;
      acc[i][accn[i] % 64] = d[i];
      accn[i]++;
      if (i == 0 && t_acc < 0) t_acc = cyc;
    end
  endtask

  task automatic decode(int i);
    int cpb;
    cpb = cpb_of(i);
    if (rst) begin
      dec_on[i] = 1'b0;
    end else if (!dec_on[i]) begin
      if (prev_tx[i] && !tx[i]) begin
        dec_on[i] = 1'b1;
        dec_t0[i] = cyc;
        dec_k[i]  = 0;
        dec_b[i]  = '0;
      end
    end else if (cyc == dec_t0[i] + dec_k[i] * cpb + cpb / 2) begin
      if (dec_k[i] == 0) begin
        check($sformatf("start_bit%0d", i), int'(tx[i]), 0);
      end else if (dec_k[i] <= 8) begin
        dec_b[i][dec_k[i]-1] = tx[i];
      end else begin
        check($sformatf("stop_bit%0d", i), int'(tx[i]), 1);
        rx[i][rxn[i] % 64] = dec_b[i];
        rxn[i]++;
        dec_on[i] = 1'b0;
      end
      dec_k[i]++;
    end
  endtask

  task automatic monitor();
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) model_step(i);
      #1;
      for (int i = 0; i < 2; i++) begin
        check($sformatf("uart_tx%0d", i), int'(tx[i]), int'(m_tx[i]));
        check($sformatf("busy%0d", i), int'(bsy[i]),
              int'(m_act[i] || msize[i] > 0));
        check($sformatf("fifo_count%0d", i), cnt[i], msize[i]);
        check($sformatf("in_ready%0d", i), int'(rdy[i]),
              int'(msize[i] < dep_of(i)));
        decode(i);
      end
      if (prev_tx[0] && !tx[0] && t_fall < 0) t_fall = cyc;
      if (prev_b0 && !bsy[0] && t_bfall < 0) t_bfall = cyc;
      if (cnt[0] > peak0) peak0 = cnt[0];
      if (prev_tx[1] && !tx[1] && t1_fall < 0) t1_fall = cyc;
      if (!prev_tx[1] && tx[1] && t1_fall >= 0 && t1_rise < 0)
        t1_rise = cyc;
      prev_tx[0] = tx[0];
      prev_tx[1] = tx[1];
      prev_b0    = bsy[0];
    end
  endtask

  task automatic clear_obs();
    t_acc   = -1;
    t_fall  = -1;
    t_bfall = -1;
    peak0   = 0;
    t1_fall = -1;
    t1_rise = -1;
    for (int i = 0; i < 2; i++) begin
      rxn[i]  = 0;
      accn[i] = 0;
    end
  endtask

  // called at a negedge; returns at the negedge after acceptance
  task automatic send(int i, logic [7:0] b, output int stalls);
    stalls = 0;
    d[i] = b;
    v[i] = 1'b1;
    while (!rdy[i] && stalls < 5000) begin
      @(negedge clk);
      stalls++;
    end
    @(negedge clk);
    v[i] = 1'b0;
  endtask

  task automatic wait_idle(int i, int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (bsy[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain_in_time%0d", i), int'(bsy[i]), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic stimulus();
    int         st, first_stall, n;
    logic [7:0] exp_b [8];

    repeat (3) @(negedge clk);
    check("rst_uart_tx", int'(tx0), 1);
    check("rst_in_ready", int'(rdy[0]), 1);
    check("rst_busy", int'(busy0), 0);
    check("rst_fifo_count", 32'(cnt0), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // single byte
    clear_obs();
    send(0, 8'h55, st);
    wait_idle(0, 200);
    check("single_rx_count", rxn[0], 1);
    check("single_rx_byte", 32'(rx[0][0]), 32'h55);
    check("single_first_zero", t_fall - t_acc, 2);
    check("single_busy_fall", t_bfall - t_acc, 1 + 10 * CPB0);

    // burst on consecutive cycles
    clear_obs();
    exp_b[0] = 8'h55;
    exp_b[1] = 8'hFF;
    exp_b[2] = 8'h00;
    exp_b[3] = 8'hAA;
    for (int k = 0; k < 4; k++) send(0, exp_b[k], st);
    wait_idle(0, 400);
    check("burst_peak", peak0, 3);
    check("burst_rx_count", rxn[0], 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("burst_byte%0d", k), 32'(rx[0][k]), 32'(exp_b[k]));
    check("burst_contiguous", t_bfall - t_acc, 1 + 4 * 10 * CPB0);

    // full FIFO with held valid
    clear_obs();
    first_stall = -1;
    for (int k = 0; k < 8; k++) begin
      exp_b[k] = 8'(8'h31 + 8'(k * 7));
      send(0, exp_b[k], st);
      if (st > 0 && first_stall < 0) first_stall = k;
    end
    wait_idle(0, 800);
    check("full_accepts_before_stall", first_stall, 5);
    check("full_rx_count", rxn[0], 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("full_byte%0d", k), 32'(rx[0][k]), 32'(exp_b[k]));

    // reset during data bit 3 of 0xA5 with two bytes queued
    clear_obs();
    send(0, 8'hA5, st);
    send(0, 8'h12, st);
    send(0, 8'h34, st);
    n = 0;
    while ((t_fall < 0 || cyc < t_fall + 17) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit3", int'(n < 200), 1);
    check("queued_before_rst", 32'(cnt0), 2);
    rst = 1'b1;
    #1;
    check("midrst_uart_tx", int'(tx0), 1);
    check("midrst_fifo_count", 32'(cnt0), 0);
    check("midrst_busy", int'(busy0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_obs();
    repeat (100) @(negedge clk);
    check("no_restart_fall", t_fall, -1);
    check("no_restart_rx", rxn[0], 0);

    // random traffic with random gaps
    clear_obs();
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(0, 8'($urandom), st);
    end
    wait_idle(0, 2000);
    check("rand_rx_count", rxn[0], accn[0]);
    check("rand_acc_count", accn[0], 20);
    for (int k = 0; k < 20; k++)
      check($sformatf("rand_byte%0d", k), 32'(rx[0][k]), 32'(acc[0][k]));

    // real baud rate
    clear_obs();
    send(1, 8'hAA, st);
    wait_idle(1, 4000);
    check("baud_rx_count", rxn[1], 1);
    check("baud_rx_byte", 32'(rx[1][0]), 32'hAA);
    check("baud_first_low_run", t1_rise - t1_fall, 2 * CPB1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i]       = 1'b0;
      d[i]       = '0;
      dec_on[i]  = 1'b0;
      prev_tx[i] = 1'b1;
      m_act[i]   = 1'b0;
      m_pos[i]   = 0;
      mhead[i]   = 0;
      msize[i]   = 0;
      m_tx[i]    = 1'b1;
    end
    prev_b0 = 1'b0;
    clear_obs();
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
